// File: rtl/sram_fifo_ctrl_if.sv
// Handshake and SRAM-side bundle for the SRAM-backed FIFO controller.
interface sram_fifo_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   level;
  logic              sram_wr_en;
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  // Controller side
  modport slave (
    input  in_valid, in_data, out_ready, sram_rdata,
    output in_ready, out_valid, out_data, level,
           sram_wr_en, sram_rd_en, sram_addr, sram_wdata
  );

  // Environment side: producer, consumer and SRAM
  modport master (
    output in_valid, in_data, out_ready, sram_rdata,
    input  in_ready, out_valid, out_data, level,
           sram_wr_en, sram_rd_en, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller using a single-port SRAM as storage; the SRAM's registered
// read data doubles as the output holding register (capacity DEPTH+1).
module sram_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input logic            clk,
  input logic            rst,
  sram_fifo_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  mem_count_q, mem_count_d;
  logic              out_valid_q, out_valid_d;

  logic              rd_issue_c;
  logic              wr_issue_c;
  logic              in_ready_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] rdata_c;

  // Issue arbitration: reads win so the output register never starves
  always_comb begin
    rd_issue_c = 1'b0;
    in_ready_c = 1'b0;
    wr_issue_c = 1'b0;
    if (rst) begin
      rd_issue_c = (mem_count_q != '0) && (!out_valid_q || bus.out_ready);
      in_ready_c = (mem_count_q != CNT_W'(DEPTH)) && !rd_issue_c;
      wr_issue_c = bus.in_valid && in_ready_c;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (wr_issue_c) begin
      wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
      mem_count_d = mem_count_q + CNT_W'(1);
    end
    if (rd_issue_c) begin
      rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
      mem_count_d = mem_count_q - CNT_W'(1);
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign wdata_c = bus.in_data;
  assign rdata_c = bus.sram_rdata;

  assign bus.in_ready   = in_ready_c;
  assign bus.sram_wr_en = wr_issue_c;
  assign bus.sram_rd_en = rd_issue_c;
  assign bus.sram_addr  = rd_issue_c ? rd_ptr_q : wr_ptr_q;
  assign bus.sram_wdata = wdata_c;
  assign bus.out_data   = rdata_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.level      = mem_count_q + CNT_W'(out_valid_q);

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- FIFO controller that uses the 16x8 single-port SRAM (sram_design) as storage and sits directly in front of it.
- Accepts a valid/ready write stream from upstream and drives the SRAM's wr_en, rd_en, addr and wdata ports.
- Presents the SRAM's registered rdata to a downstream valid/ready consumer in FIFO order.
- Arbitrates the SRAM's single shared address port so that at most one access occurs per cycle.

Parameters:
- DATA_W, 8, data width; must match the SRAM word width.
- ADDR_W, 4, SRAM address width; DEPTH = 2**ADDR_W = 16 entries.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream write request.
- in_ready  output  1  controller accepts in_data this cycle.
- in_data  input  DATA_W  write data.
- out_valid  output  1  out_data holds the FIFO head.
- out_ready  input  1  downstream consumes the head this cycle.
- out_data  output  DATA_W  FIFO head; wired directly from sram_rdata.
- level  output  ADDR_W+1  occupancy = mem_count + out_valid (0..DEPTH+1).
- sram_wr_en  output  1  to SRAM wr_en.
- sram_rd_en  output  1  to SRAM rd_en.
- sram_addr  output  ADDR_W  to SRAM addr.
- sram_wdata  output  DATA_W  to SRAM wdata.
- sram_rdata  input  DATA_W  from SRAM rdata; registered, one-cycle read latency, holds its value until the next read.

Behaviour:
- Reset: one clock; rst is asynchronous, active-low.
  - While rst=0, wr_ptr, rd_ptr and mem_count clear to 0, and out_valid=0.
  - While rst=0, in_ready, sram_wr_en and sram_rd_en are forced to 0.
  - The SRAM's own active-high synchronous reset is driven at top level from ~rst.
- Reset mid-operation: all in-flight data is discarded; SRAM contents are stale and ignored.
- State: wr_ptr[ADDR_W-1:0], rd_ptr[ADDR_W-1:0], mem_count[ADDR_W:0] (entries held in SRAM, not yet read), out_valid.
- Combinational issue rules:
  - rd_issue = (mem_count!=0) && (!out_valid || out_ready).
  - in_ready = (mem_count!=DEPTH) && !rd_issue.
  - wr_issue = in_valid && in_ready.
  - Read has priority over write; rd_issue and wr_issue are never both 1.
  - in_ready depends combinationally on out_ready.
- SRAM drive:
  - sram_rd_en = rd_issue; sram_wr_en = wr_issue.
  - sram_addr = rd_issue ? rd_ptr : wr_ptr.
  - sram_wdata = in_data.
  - sram_wr_en and sram_rd_en are never asserted together.
- Clock edge updates:
  - wr_issue: wr_ptr+1 (wraps 15->0 modulo DEPTH); mem_count+1.
  - rd_issue: rd_ptr+1 (wraps); mem_count-1.
  - out_valid next = rd_issue ? 1 : (out_valid && !out_ready).
- Pop without refill: an out_valid&&out_ready pop with no rd_issue clears out_valid.
- Pop with refill: a pop with rd_issue keeps out_valid=1, and new data appears on sram_rdata after the same edge, giving back-to-back throughput of 1 word/cycle.
- Latency: a word accepted into an empty FIFO at edge E0 is read at E1 and is valid on out_data after E1 (2 cycles).
- Full:
  - mem_count==DEPTH drives in_ready=0. Total capacity is 17 (16 in SRAM + 1 held in the rdata register).
  - A write never overwrites an unread entry.
- Empty: mem_count==0 means no read is issued; out_valid holds its state.
- Write starvation bound: under a continuously ready consumer, writes stall at most mem_count cycles (until the SRAM drains). Reads then alternate with writes.
- Stability: out_data must not change while out_valid=1 && !out_ready, because no read is issued in that case.
- level is registered-state derived: mem_count + out_valid.

Test Plan:
- Reset: assert rst=0 mid-stream with level=5 -> all outputs 0, level=0 immediately (asynchronous). After release, write 0xA5 -> out_data=0xA5 with out_valid=1 two cycles after acceptance.
- Ordering: out_ready=0, push 0x00..0x10 (17 words) -> level=17, in_ready=0 on the 18th attempt. Then out_ready=1 -> 0x00..0x10 pop in order with no gaps.
- Wrap-around: 3 rounds of push 10 / pop 10 (pointers cross 15->0) -> data intact; rd_ptr and wr_ptr both end at 14.
- Backpressure: out_valid=1 with out_data=0x3C and out_ready=0 for 5 cycles -> out_data stays 0x3C, sram_rd_en=0, and writes proceed (in_ready=1 while mem_count<16).
- Arbitration: mem_count=4, out_ready=1, in_valid=1 -> in_ready=0 for 4 cycles while reads drain, then a write is accepted. sram_wr_en&&sram_rd_en is never 1 (assertion).
- Empty: single push 0x77 followed by an immediate pop -> out_valid drops to 0, no further sram_rd_en, level returns to 0.
